// File: rtl/la_pkg.sv
// Shared types and default sizing for the logic-analyzer capture core.
package la_pkg;

  localparam int LA_DATA_W_DEF = 8;
  localparam int LA_DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    POST = 2'd2,
    READ = 2'd3
  } la_state_e;

endpackage

// File: rtl/la_capture_core_if.sv
// Readout stream (valid/ready) from the capture core to the readout logic.
interface la_capture_core_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic              rd_last_o;
  logic              rd_ready_i;

  // Capture core drives the sample stream.
  modport master (
    output rd_data_o,
    output rd_valid_o,
    output rd_last_o,
    input  rd_ready_i
  );

  // Readout logic consumes it.
  modport slave (
    input  rd_data_o,
    input  rd_valid_o,
    input  rd_last_o,
    output rd_ready_i
  );

endinterface

// File: rtl/la_sdp_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The array carries no reset so it maps onto block RAM.
module la_sdp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; output holds while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: circular sample buffer, masked-match trigger,
// programmable post-trigger count, oldest-first readout over valid/ready.
// Optional macro LA_EDGE_TRIG_EN adds trig_edge_i (match-entry trigger).
module la_capture_core
  import la_pkg::*;
#(
  parameter  int DATA_W = LA_DATA_W_DEF,
  parameter  int DEPTH  = LA_DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [ADDR_W-1:0] post_cnt_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef LA_EDGE_TRIG_EN
  input  logic              trig_edge_i,
`endif
  output logic              busy_o,
  output logic              trig_o,
  output logic [ADDR_W-1:0] trig_addr_o,
  output logic              done_o,
  la_capture_core_if.master rd
);

  localparam logic [ADDR_W:0] FILL_FULL = (ADDR_W+1)'(DEPTH);

  la_state_e         state_reg;
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg, trig_addr_reg, pcnt_reg, post_reg;
  logic [ADDR_W:0]   fill_reg, fetch_left_reg;
  logic [DATA_W-1:0] mask_reg, value_reg;
  logic              busy_reg, done_reg, trig_reg, rd_valid_reg, rd_last_reg;
  logic [DATA_W-1:0] ram_q;

  logic              writing, we, match, trig_hit, load, re, enter_read;
  logic [ADDR_W-1:0] wr_ptr_inc, rd_start;
  logic [ADDR_W:0]   fill_inc;

  assign match      = ((data_i ^ value_reg) & mask_reg) == '0;
  assign writing    = (state_reg == ARM) || (state_reg == POST);
  assign we         = writing && !abort_i && !rst;
  assign wr_ptr_inc = wr_ptr_reg + 1'b1;
  assign fill_inc   = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;
  // Oldest sample of the window once the current write has landed.
  assign rd_start   = wr_ptr_inc - fill_inc[ADDR_W-1:0];

`ifdef LA_EDGE_TRIG_EN
  logic edge_reg, prev_match_reg, prev_valid_reg;
  assign trig_hit = match && (!edge_reg || (prev_valid_reg && !prev_match_reg));
`else
  assign trig_hit = match;
`endif

  assign enter_read = ((state_reg == ARM) && trig_hit && (post_reg == '0)) ||
                      ((state_reg == POST) && (pcnt_reg == ADDR_W'(1)));

  // Output slot frees up this cycle: either empty or being consumed.
  assign load = !rd_valid_reg || rd.rd_ready_i;
  assign re   = (state_reg == READ) && load && (fetch_left_reg != '0) && !abort_i;

  la_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_reg),
    .wdata (data_i),
    .re    (re),
    .raddr (rd_ptr_reg),
    .rdata (ram_q)
  );

  // Capture/readout FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      trig_addr_reg  <= '0;
      pcnt_reg       <= '0;
      post_reg       <= '0;
      fill_reg       <= '0;
      fetch_left_reg <= '0;
      mask_reg       <= '0;
      value_reg      <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      trig_reg       <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
`ifdef LA_EDGE_TRIG_EN
      edge_reg       <= 1'b0;
      prev_match_reg <= 1'b0;
      prev_valid_reg <= 1'b0;
`endif
    end else if (abort_i) begin
      state_reg    <= IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      trig_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
    end else begin
      trig_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (arm_i) begin
            mask_reg  <= trig_mask_i;
            value_reg <= trig_value_i;
            post_reg  <= post_cnt_i;
            fill_reg  <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ARM;
`ifdef LA_EDGE_TRIG_EN
            edge_reg       <= trig_edge_i;
            prev_valid_reg <= 1'b0;
`endif
          end
        end
        ARM: begin
          wr_ptr_reg <= wr_ptr_inc;
          fill_reg   <= fill_inc;
          if (trig_hit) begin
            trig_reg      <= 1'b1;
            trig_addr_reg <= wr_ptr_reg;
            pcnt_reg      <= post_reg;
            if (post_reg != '0) state_reg <= POST;
          end
        end
        POST: begin
          wr_ptr_reg <= wr_ptr_inc;
          fill_reg   <= fill_inc;
          pcnt_reg   <= pcnt_reg - 1'b1;
        end
        READ: begin
          if (load) begin
            if (fetch_left_reg != '0) begin
              rd_ptr_reg     <= rd_ptr_reg + 1'b1;
              fetch_left_reg <= fetch_left_reg - 1'b1;
              rd_valid_reg   <= 1'b1;
              rd_last_reg    <= (fetch_left_reg == (ADDR_W+1)'(1));
            end else begin
              // Final sample was just accepted.
              state_reg    <= IDLE;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b0;
              rd_valid_reg <= 1'b0;
              rd_last_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
`ifdef LA_EDGE_TRIG_EN
      if (writing) begin
        prev_match_reg <= match;
        prev_valid_reg <= 1'b1;
      end
`endif
      if (enter_read) begin
        state_reg      <= READ;
        done_reg       <= 1'b1;
        rd_ptr_reg     <= rd_start;
        fetch_left_reg <= fill_inc;
      end
    end
  end

  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign trig_o        = trig_reg;
  assign trig_addr_o   = trig_addr_reg;
  assign rd.rd_valid_o = rd_valid_reg;
  assign rd.rd_last_o  = rd_last_reg;
  assign rd.rd_data_o  = rd_valid_reg ? ram_q : '0;

endmodule

// File: tb/tb_la_capture_core.sv
// Scoreboard bench for la_capture_core (DATA_W=8, DEPTH=16).
module tb_la_capture_core;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] mask = '0;
  logic [DW-1:0] value = '0;
  logic [AW-1:0] post = '0;
  logic [DW-1:0] data = '0;
  logic          trig_edge = 1'b0;
  logic          busy, trig, done;
  logic [AW-1:0] trig_addr;
  logic          rd_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int rdy_mode = 0;
  int bp_idx = 0;
  int bp_pat [4] = '{1, 0, 0, 1};

  logic [8:0]    exp_q [$];   // {last, data}
  logic [AW-1:0] trig_q [$];

  la_capture_core_if #(.DATA_W(DW)) rif ();
  assign rif.rd_ready_i = rd_ready;

  la_capture_core #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_mask_i  (mask),
    .trig_value_i (value),
    .post_cnt_i   (post),
    .data_i       (data),
`ifdef LA_EDGE_TRIG_EN
    .trig_edge_i  (trig_edge),
`endif
    .busy_o       (busy),
    .trig_o       (trig),
    .trig_addr_o  (trig_addr),
    .done_o       (done),
    .rd           (rif.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consumer ready pattern: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rd_ready = 1'b1;
      1: begin
        rd_ready = bp_pat[bp_idx] != 0;
        bp_idx   = (bp_idx + 1) % 4;
      end
      default: rd_ready = 1'b0;
    endcase
  end

  // Readout monitor: compare every presented sample with the queue head.
  always @(negedge clk) begin
    if (rif.rd_valid_o) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", {23'd0, rif.rd_last_o, rif.rd_data_o}, 32'h1ff);
      end else begin
        check("rd_sample", {23'd0, rif.rd_last_o, rif.rd_data_o}, {23'd0, exp_q[0]});
        $display("rd data=%02h last=%0d ready=%0d", rif.rd_data_o, rif.rd_last_o, rd_ready);
        if (rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Trigger monitor.
  always @(negedge clk) begin
    if (trig) begin
      if (trig_q.size() == 0) begin
        check("trig_unexpected", {28'd0, trig_addr}, 32'hffff);
      end else begin
        check("trig_addr", {28'd0, trig_addr}, {28'd0, trig_q[0]});
        $display("trig addr=%0d", trig_addr);
        void'(trig_q.pop_front());
      end
    end
  end

  task automatic push_ramp(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back({(i == last), 8'(i)});
  endtask

  task automatic do_arm(input logic [7:0] m, input logic [7:0] v, input logic [3:0] p);
    mask = m; value = v; post = p;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Run until busy drops; optionally ramp data from 0 starting at the first write.
  task automatic wait_idle(input string name, input bit ramp, input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      if (ramp) data = 8'(k);
      tick();
      k++;
    end
    if (busy) check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic end_check(input string name);
    check({name, "_rd_left"}, exp_q.size(), 0);
    check({name, "_trig_left"}, trig_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig", trig, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_valid", rif.rd_valid_o, 0);
    check("rst_last", rif.rd_last_o, 0);
    check("rst_data", rif.rd_data_o, 0);

    // 1: basic capture, wr_ptr starts at 0.
    push_ramp(0, 8); trig_q.push_back(4'd5);
    do_arm(8'hff, 8'h05, 4'd3);
    wait_idle("t1", 1'b1, 100);
    end_check("t1");

    // 2: wrap-around, wr_ptr base 9.
    push_ramp(8'h15, 8'h24); trig_q.push_back(4'd9);
    do_arm(8'hff, 8'h20, 4'd4);
    wait_idle("t2", 1'b1, 200);
    end_check("t2");

    // 3: immediate trigger, wr_ptr base 14.
    exp_q.push_back({1'b1, 8'haa}); trig_q.push_back(4'd14);
    do_arm(8'h00, 8'h00, 4'd0);
    data = 8'haa;
    tick();
    check("t3_done_after_one_arm", done, 1);
    wait_idle("t3", 1'b0, 20);
    end_check("t3");

    // 4: backpressure, wr_ptr base 15.
    rdy_mode = 1; bp_idx = 0;
    push_ramp(0, 8); trig_q.push_back(4'd4);
    do_arm(8'hff, 8'h05, 4'd3);
    wait_idle("t4", 1'b1, 200);
    end_check("t4");
    rdy_mode = 0;

    // 5a: abort mid-POST, wr_ptr base 8; seven writes happen.
    trig_q.push_back(4'd13);
    do_arm(8'hff, 8'h05, 4'd10);
    for (int k = 0; k < 7; k++) begin data = 8'(k); tick(); end
    abort = 1'b1; data = 8'h07;
    tick();
    abort = 1'b0;
    check("t5a_busy", busy, 0);
    check("t5a_done", done, 0);
    check("t5a_valid", rif.rd_valid_o, 0);
    end_check("t5a");

    // abort beats arm in IDLE
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("t5_abort_wins", busy, 0);

    // 5b: re-arm completes, wr_ptr base 15.
    push_ramp(0, 5); trig_q.push_back(4'd2);
    do_arm(8'hff, 8'h03, 4'd2);
    wait_idle("t5b", 1'b1, 100);
    end_check("t5b");

    // 5c: reset mid-READ under stall, wr_ptr base 5.
    rdy_mode = 2;
    push_ramp(0, 3); trig_q.push_back(4'd7);
    do_arm(8'hff, 8'h02, 4'd1);
    for (int k = 0; k < 6; k++) begin data = 8'(k); tick(); end
    check("t5c_done", done, 1);
    check("t5c_valid", rif.rd_valid_o, 1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    rdy_mode = 0;
    check("t5c_busy", busy, 0);
    check("t5c_done0", done, 0);
    check("t5c_valid0", rif.rd_valid_o, 0);
    check("t5c_last0", rif.rd_last_o, 0);
    check("t5c_data0", rif.rd_data_o, 0);
    check("t5c_trig0", trig, 0);
    check("t5c_taddr0", trig_addr, 0);
    end_check("t5c");

    // Post-reset immediate capture: pointer restarts at 0.
    exp_q.push_back({1'b1, 8'h3c}); trig_q.push_back(4'd0);
    do_arm(8'h00, 8'h00, 4'd0);
    data = 8'h3c;
    tick();
    check("t5d_done", done, 1);
    wait_idle("t5d", 1'b0, 20);
    end_check("t5d");

`ifdef LA_EDGE_TRIG_EN
    // 6: edge mode, wr_ptr base 1; writes 05,05,06,05,07.
    trig_edge = 1'b1;
    exp_q.push_back({1'b0, 8'h05}); exp_q.push_back({1'b0, 8'h05});
    exp_q.push_back({1'b0, 8'h06}); exp_q.push_back({1'b0, 8'h05});
    exp_q.push_back({1'b1, 8'h07});
    trig_q.push_back(4'd4);
    data = 8'h05;
    do_arm(8'hff, 8'h05, 4'd1);
    data = 8'h05; tick();
    data = 8'h05; tick();
    data = 8'h06; tick();
    data = 8'h05; tick();
    data = 8'h07; tick();
    wait_idle("t6", 1'b0, 50);
    end_check("t6");
    trig_edge = 1'b0;
`endif

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/la_capture_core.md
Name: la_capture_core

Overview:
- Parametrised on-chip logic-analyzer capture core; next generation of the 8-bit debug-probe capture path.
- Samples a DATA_W-bit probe bus every clk into a circular buffer of DEPTH entries.
- Triggers on a masked value match and keeps a programmable number of post-trigger samples.
- Streams the captured window oldest-first over a valid/ready port to the JTAG/UART readout logic.

Parameters:
- DATA_W, 8, probe bus width (1..64).
- DEPTH, 256, buffer entries; power of two, >= 4.
- ADDR_W (localparam), $clog2(DEPTH), buffer address width; not overridable.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm_i  in  1  start a capture; accepted only in IDLE.
- abort_i  in  1  cancel the current capture or readout.
- trig_mask_i  in  DATA_W  bits taking part in the compare; latched on arm.
- trig_value_i  in  DATA_W  compare value; latched on arm.
- post_cnt_i  in  ADDR_W  samples kept after the trigger sample; latched on arm.
- data_i  in  DATA_W  probe bus.
- busy_o  out  1  high in ARM, POST and READ.
- trig_o  out  1  one-cycle pulse, registered, cycle after the trigger sample is written.
- trig_addr_o  out  ADDR_W  buffer address of the trigger sample.
- done_o  out  1  high throughout READ.
- rd_data_o  out  DATA_W  readout sample.
- rd_valid_o  out  1  readout valid.
- rd_last_o  out  1  marks the final sample; qualified by rd_valid_o.
- rd_ready_i  in  1  readout consumer ready.

Behaviour:
- Reset: all outputs 0; state IDLE; wr_ptr=0; fill=0.
- States: IDLE, ARM, POST, READ.
- IDLE:
  - arm_i latches mask, value and post_cnt, clears fill, and moves to ARM.
  - The first sample is written in the first ARM cycle.
- ARM:
  - Each cycle: mem[wr_ptr]<=data_i; wr_ptr++ (wraps mod DEPTH); fill saturates at DEPTH.
  - Trigger condition: (data_i & mask) == (value & mask), evaluated on the sample being written.
  - On trigger: trig_addr<=wr_ptr; pcnt<=post_cnt.
  - post_cnt==0: go straight to READ. Otherwise go to POST.
  - mask==0 triggers on the first ARM cycle.
- POST:
  - Keeps writing as in ARM; pcnt decrements per write.
  - Moves to READ after the write that brings pcnt to 0.
  - post_cnt <= DEPTH-1 by width, so the trigger sample is never overwritten.
- READ:
  - Window length N = fill at entry (1..DEPTH); start address = wr_ptr - N mod DEPTH.
  - RAM read is synchronous: rd_valid_o rises 1 cycle after READ entry.
  - rd_data_o and rd_last_o hold stable while rd_valid_o && !rd_ready_i.
  - One sample advances per handshake cycle; back-to-back throughput is 1 sample/clk.
  - rd_last_o is asserted on sample N. Its handshake returns to IDLE with rd_valid_o low next cycle.
- arm_i outside IDLE is ignored.
- abort_i, any state: IDLE next cycle; rd_valid_o, done_o and busy_o go low; buffer contents undefined.
- rst mid-operation behaves like abort_i and also clears pointers.
- abort_i and arm_i in the same IDLE cycle: abort_i wins.
- trig_o pulses only once per capture.

Optional Feature:
- Macro: LA_EDGE_TRIG_EN.
- Defined:
  - Adds input trig_edge_i (1 bit), latched on arm.
  - When latched 1, the trigger requires a match on the current sample AND no match on the previous written sample.
  - The first ARM cycle cannot trigger in edge mode (no previous sample).
  - When latched 0, behaviour is identical to level mode.
- Not defined: port absent; level-match trigger only; no previous-sample register.

Decomposition:
- Package la_pkg:
  - State enum la_state_e {IDLE, ARM, POST, READ}.
  - Default DATA_W and DEPTH constants.
- Sub-module la_sdp_ram:
  - Simple dual-port RAM (write port, synchronous read port), DATA_W x DEPTH, no reset on the array.
  - Infers block RAM.

Test Plan (DATA_W=8, DEPTH=16):
1. Basic capture:
   - Stimulus: arm, mask=FF, value=05, post=3, data ramp 00,01,...
   - Required: trig_o one cycle after 05 is written; trig_addr_o=5; readout 00..08 (9 samples); rd_last_o on 08.
2. Wrap-around:
   - Stimulus: ramp from 00, value=20, post=4.
   - Required: readout exactly 16 samples 15..24; trigger sample 20 present.
3. Immediate trigger:
   - Stimulus: mask=00, post=0, data=AA.
   - Required: READ after one ARM cycle; single sample AA with rd_last_o=1.
4. Backpressure:
   - Stimulus: case 1 with rd_ready_i toggling 1,0,0,1,...
   - Required: rd_data_o stable while stalled; all 9 samples in order with none lost or duplicated.
5. Abort and reset:
   - Stimulus: abort_i mid-POST; re-arm; then assert rst mid-READ.
   - Required: busy_o=0 next cycle each time; the second capture completes correctly; all outputs 0 after rst.
6. Edge mode (LA_EDGE_TRIG_EN, trig_edge_i=1):
   - Stimulus: data=05 held at arm, then 06, then 05; value=05.
   - Required: no trigger on the held 05; trigger on the re-entry 05.
